// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-transaction I2C master: START, address+R/W, ACK check, one byte, STOP
// Optional MASTER_AUTO_RESTART_EN: DONE lasts one tick, then a fresh transaction starts.
module i2c_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         CLK_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] state,
  output logic       sclk,
  input  logic       sda_in,
  output logic       sda_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [2:0]    state_q, state_d;
  logic          sclk_q, sclk_d;
  logic          sda_q, sda_d;
  logic [7:0]    data_out_q, data_out_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    step_q, step_d;
  logic          ack_slot_q, ack_slot_d;
  logic          stop_q, stop_d;
  logic [7:0]    addr_byte;
  logic [2:0]    bit_nxt;
  logic          slot_state;

  assign tick       = (tick_cnt_q == TW'(CLK_DIV - 1));
  assign addr_byte  = {SLAVE_ADDR, rw_q};
  assign bit_nxt    = bit_cnt_q + 3'd1;
  assign slot_state = (state_q == S_ADDR) || (state_q == S_WAIT) ||
                      (state_q == S_READ) || (state_q == S_WRITE);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    state_d    = state_q;
    sclk_d     = sclk_q;
    sda_d      = sda_q;
    data_out_d = data_out_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    bit_cnt_d  = bit_cnt_q;
    step_d     = step_q;
    ack_slot_d = ack_slot_q;
    stop_d     = stop_q;

    if (tick) begin
      if (stop_q) begin
        // STOP keeps the state code of the phase that requested it
        if (step_q == 2'd0) begin
          sclk_d = 1'b1;
          step_d = 2'd1;
        end else begin
          sda_d   = 1'b1;
          stop_d  = 1'b0;
          step_d  = 2'd0;
          state_d = S_DONE;
        end
      end else if (slot_state && !sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            case (step_q)
              2'd0: step_d = 2'd1;
              2'd1: begin
                sda_d  = 1'b0;
                step_d = 2'd2;
              end
              default: begin
                state_d   = S_ADDR;
                sclk_d    = 1'b0;
                sda_d     = SLAVE_ADDR[6];
                bit_cnt_d = 3'd0;
                step_d    = 2'd0;
                rw_d      = rw;
                wdata_d   = data_in;
              end
            endcase
          end
          S_ADDR: begin
            sclk_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              state_d   = S_WAIT;
              sda_d     = 1'b1;
              bit_cnt_d = 3'd0;
            end else begin
              bit_cnt_d = bit_nxt;
              sda_d     = addr_byte[3'd7 - bit_nxt];
            end
          end
          S_WAIT: begin
            sclk_d = 1'b0;
            if (!sda_in) begin
              state_d = rw_q ? S_READ : S_WRITE;
              sda_d   = rw_q ? 1'b1 : wdata_q[7];
            end else begin
              stop_d = 1'b1;
              sda_d  = 1'b0;
            end
          end
          S_READ: begin
            sclk_d = 1'b0;
            if (ack_slot_q) begin
              ack_slot_d = 1'b0;
              stop_d     = 1'b1;
              sda_d      = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], sda_in};
              sda_d   = 1'b1;
              if (bit_cnt_q == 3'd7) begin
                data_out_d = {shift_q[6:0], sda_in};
                ack_slot_d = 1'b1;
                bit_cnt_d  = 3'd0;
              end else begin
                bit_cnt_d = bit_nxt;
              end
            end
          end
          S_WRITE: begin
            sclk_d = 1'b0;
            if (ack_slot_q) begin
              // slave ACK after the data byte is not acted upon
              ack_slot_d = 1'b0;
              stop_d     = 1'b1;
              sda_d      = 1'b0;
            end else if (bit_cnt_q == 3'd7) begin
              ack_slot_d = 1'b1;
              sda_d      = 1'b1;
              bit_cnt_d  = 3'd0;
            end else begin
              bit_cnt_d = bit_nxt;
              sda_d     = wdata_q[3'd7 - bit_nxt];
            end
          end
          S_DONE: begin
`ifdef MASTER_AUTO_RESTART_EN
            state_d = S_IDLE;
`else
            state_d = S_DONE;
`endif
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      sclk_q     <= 1'b1;
      sda_q      <= 1'b1;
      data_out_q <= 8'h00;
      shift_q    <= 8'h00;
      wdata_q    <= 8'h00;
      rw_q       <= 1'b0;
      bit_cnt_q  <= 3'd0;
      step_q     <= 2'd0;
      ack_slot_q <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      sda_q      <= sda_d;
      data_out_q <= data_out_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      bit_cnt_q  <= bit_cnt_d;
      step_q     <= step_d;
      ack_slot_q <= ack_slot_d;
      stop_q     <= stop_d;
    end
  end

  assign data_out = data_out_q;
  assign state    = state_q;
  assign sclk     = sclk_q;
  assign sda_out  = sda_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - self-checking bench for i2c_master against a tick-level bus waveform model
module tb_i2c_master;

  localparam int DIV = 2;
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, WAIT = 3'd2, READ = 3'd3, WRITE = 3'd4, DONE = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       sda_in = 1'b1;
  logic [7:0] data_out;
  logic [2:0] state;
  logic       sclk;
  logic       sda_out;

  always #5 clk = ~clk;

  i2c_master #(.SLAVE_ADDR(7'h50), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .rw(rw), .data_in(data_in), .data_out(data_out),
    .state(state), .sclk(sclk), .sda_in(sda_in), .sda_out(sda_out)
  );

  typedef struct packed {
    logic       sclk;
    logic       sda;
    logic [2:0] st;
    logic       sin;
    logic [7:0] dout;
  } ent_t;

  ent_t       tr[$];
  logic [7:0] exp_dout;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one entry per tick: bus/state values after the tick, plus what the slave drives during it
  function automatic void push(logic sc, logic sd, logic [2:0] st, logic si);
    ent_t e;
    e.sclk = sc; e.sda = sd; e.st = st; e.sin = si; e.dout = exp_dout;
    tr.push_back(e);
  endfunction

  function automatic void push_slot(logic sd, logic [2:0] st, logic si);
    push(1'b0, sd, st, si);
    push(1'b1, sd, st, si);
  endfunction

  function automatic void push_stop(logic [2:0] st);
    push(1'b0, 1'b0, st, 1'b1);
    push(1'b1, 1'b0, st, 1'b1);
    push(1'b1, 1'b1, DONE, 1'b1);
  endfunction

  function automatic void build(logic r, logic [7:0] wbyte, logic nack, logic [7:0] rbyte, logic wack);
    logic [7:0] abyte;
    tr.delete();
    exp_dout = 8'h00;
    abyte = {7'h50, r};
    push(1'b1, 1'b1, IDLE, 1'b1);
    push(1'b1, 1'b1, IDLE, 1'b1);
    push(1'b1, 1'b0, IDLE, 1'b1);
    for (int i = 7; i >= 0; i--) push_slot(abyte[i], ADDR, 1'b1);
    push_slot(1'b1, WAIT, nack);
    if (nack) begin
      push_stop(WAIT);
    end else if (r) begin
      for (int i = 7; i >= 0; i--) push_slot(1'b1, READ, rbyte[i]);
      exp_dout = rbyte;
      push_slot(1'b1, READ, 1'b1);
      push_stop(READ);
    end else begin
      for (int i = 7; i >= 0; i--) push_slot(wbyte[i], WRITE, 1'b1);
      push_slot(1'b1, WRITE, wack);
      push_stop(WRITE);
    end
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, DONE, 1'b1);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
    chk({tag, "_sclk"}, 32'(sclk), 32'd1);
    chk({tag, "_sda"}, 32'(sda_out), 32'd1);
    chk({tag, "_dout"}, 32'(data_out), 32'h00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
  endtask

  // starts from a negedge with rst low; abort_idx >= 0 returns once that trace entry is checked
  task automatic run_txn(input logic r, input logic [7:0] wbyte, input logic nack,
                         input logic [7:0] rbyte, input logic wack, input int abort_idx);
    int  idx;
    bit  scrambled;
    scrambled = 1'b0;
    build(r, wbyte, nack, rbyte, wack);
    rw = r;
    data_in = wbyte;
    rst = 1'b1;
    for (int n = 1; n < tr.size() * DIV; n++) begin
      sda_in = tr[(n - 1) / DIV].sin;
      @(posedge clk);
      @(negedge clk);
      idx = n / DIV;
      chk($sformatf("sclk@%0d", idx), 32'(sclk), 32'(tr[idx].sclk));
      chk($sformatf("sda@%0d", idx), 32'(sda_out), 32'(tr[idx].sda));
      chk($sformatf("state@%0d", idx), 32'(state), 32'(tr[idx].st));
      chk($sformatf("dout@%0d", idx), 32'(data_out), 32'(tr[idx].dout));
      if (!scrambled && tr[idx].st == ADDR) begin
        rw = ~r;
        data_in = 8'($urandom);
        scrambled = 1'b1;
      end
      if (idx == abort_idx) return;
    end
    chk("final_state", 32'(state), 32'(DONE));
    chk("final_dout", 32'(data_out), 32'(nack ? 8'h00 : (r ? rbyte : 8'h00)));
    sda_in = 1'b1;
  endtask

  initial begin
    logic       r;
    logic [7:0] b;
    do_reset();
    run_txn(1'b1, 8'h00, 1'b0, 8'hF6, 1'b0, -1);

    do_reset();
    run_txn(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, -1);

    do_reset();
    run_txn(1'($urandom), 8'($urandom), 1'b1, 8'($urandom), 1'b0, -1);

    do_reset();
    run_txn(1'b1, 8'h00, 1'b0, 8'($urandom), 1'b0, 29);
    chk("abort_pre_state", 32'(state), 32'(READ));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midreset");
    run_txn(1'b0, 8'($urandom), 1'b0, 8'h00, 1'($urandom), -1);

    for (int k = 0; k < 4; k++) begin
      r = 1'($urandom);
      b = 8'($urandom);
      do_reset();
      run_txn(r, b, ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-transaction I2C bus master: issues START, sends a 7-bit slave address plus R/W bit, checks the slave ACK, then reads or writes one data byte, issues STOP and reports completion.
- Sits between a local byte interface (rw, data_in, data_out) and a split-direction I2C pin pair (sda_in/sda_out, open-drain buffer external).
- Exposes its FSM state for bench and debug monitoring.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address, sent MSB first.
- CLK_DIV, 1, clk cycles per sclk half-period ("tick"). Must be ≥1; default gives sclk = clk/2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- rw  input  1  1 = read byte from slave, 0 = write data_in; sampled when ADDRESSING is entered.
- data_in  input  8  byte to write; captured when ADDRESSING is entered.
- data_out  output  8  last byte read; updated only after 8 received bits.
- state  output  3  0 IDLE, 1 ADDRESSING, 2 WAITING, 3 READING, 4 WRITING, 5 DONE.
- sclk  output  1  I2C clock.
- sda_in  input  1  sampled SDA line.
- sda_out  output  1  driven SDA value; 1 = released/high.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, sclk=1, sda_out=1, data_out=8'h00, bit counter=0, tick counter=0.
- Tick: internal counter; one tick every CLK_DIV clk cycles. All sclk/sda_out changes occur only on ticks. Registered outputs; no combinational paths to outputs.
- Bit slot = 2 ticks: low phase (sclk=0, sda_out updated on entry), then high phase (sclk=1, sda_out stable). sda_out never changes while sclk=1, except for START/STOP.
- Received bits are sampled from sda_in on the tick ending the high phase (sclk 1→0).
- IDLE: after reset release, one tick with sclk=1, sda_out=1; next tick sda_out←0 with sclk=1 (START); next tick enter ADDRESSING with sclk←0.
- ADDRESSING: 8 bit slots: SLAVE_ADDR[6:0] MSB first, then rw. After 8th slot → WAITING.
- WAITING (ACK slot): sda_out=1 (released); one bit slot; sample sda_in at end of high phase.
  - sda_in=0 (ACK): → READING if latched rw=1, else → WRITING.
  - sda_in=1 (NACK): go to STOP sequence, then DONE; data_out unchanged.
- READING: 8 bit slots, sda_out=1; shift sda_in in MSB first. After 8th, data_out←shifted byte, then one master-NACK slot (sda_out=1), then STOP.
- WRITING: 8 bit slots, latched data_in MSB first; then one ACK slot (sda_out=1, sda_in sampled, result ignored), then STOP. The state code stays WRITING through that slot.
- STOP (state code stays that of the preceding phase): tick with sclk=0, sda_out=0; tick sclk←1; tick sda_out←1 (STOP); → DONE.
- DONE: sclk=1, sda_out=1; terminal until reset (see Optional Feature).
- Reset asserted mid-transaction: abort immediately to reset values. No STOP is generated.
- rw/data_in changes after ADDRESSING entry are ignored for that transaction.

Optional Feature:
- MASTER_AUTO_RESTART_EN:
  - Defined: DONE lasts one tick, then returns to IDLE. A new transaction (fresh START, rw/data_in re-sampled) follows automatically.
  - Undefined: DONE holds forever until reset.

Test Plan:
- Reset: rst=0 for 2 clks → state=0, sclk=1, sda_out=1, data_out=8'h00. Release: sda_out falls while sclk=1 (START), then state=1.
- Address/read ACK: rw=1, SLAVE_ADDR=7'h50. Bench samples sda_out on sclk rises → 1,0,1,0,0,0,0,1. Bench drives sda_in=0 in WAITING → state=3.
- Read byte: slave drives 8'hF6 MSB first on sclk low phases → data_out=8'hF6. Master NACK slot shows sda_out=1. STOP observed; state=5.
- Write: rw=0, data_in=8'hA5, ACK given → state=4. sda_out bits on sclk rises 1,0,1,0,0,1,0,1 → STOP → state=5, data_out unchanged.
- NACK: sda_in held 1 in WAITING → STOP then state=5. No READING/WRITING entered.
- Mid-reset: rst=0 during READING bit 4 → next clk state=0, sclk=1, sda_out=1, data_out=8'h00. Restart on release with a fresh START.
